// File: rtl/compuertas_logicas.sv
// compuertas_logicas: run-time selectable 3-input gate with enable and registered output
// Ports: clk rising-edge clock; rst async active-high reset; ent1..ent3 data bits;
//        act enable (0 forces 0); sel gate code; sal registered result
module compuertas_logicas (
    input  logic       clk,
    input  logic       rst,
    input  logic       ent1,
    input  logic       ent2,
    input  logic       ent3,
    input  logic       act,
    input  logic [2:0] sel,
    output logic       sal
);
    logic sal_d, sal_q, y_and, y_or, y_xor;
    assign y_and = ent1 & ent2 & ent3;
    assign y_or  = ent1 | ent2 | ent3;
    assign y_xor = ent1 ^ ent2 ^ ent3;
    // codes 000 and 111 decode to 0, as does act=0
    always_comb begin
        sal_d = !act        ? 1'b0 :
                sel == 3'd1 ? y_and :
                sel == 3'd2 ? y_or :
                sel == 3'd3 ? y_xor :
                sel == 3'd4 ? ~y_and :
                sel == 3'd5 ? ~y_or :
                sel == 3'd6 ? ~y_xor : 1'b0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sal_q <= 1'b0;
        else     sal_q <= sal_d;
    end
    assign sal = sal_q;
endmodule

// File: tb/tb_compuertas_logicas.sv
// tb_compuertas_logicas: directed self-checking bench for compuertas_logicas
module tb_compuertas_logicas;
    logic clk = 1'b0, rst, ent1, ent2, ent3, act, sal;
    logic [2:0] sel;
    int n_cmp = 0, n_err = 0;
    compuertas_logicas dut (
        .clk(clk), .rst(rst), .ent1(ent1), .ent2(ent2), .ent3(ent3),
        .act(act), .sel(sel), .sal(sal)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask
    // exp bit i is the result for {ent3,ent2,ent1} = i
    task automatic sweep(input string tag, input logic [2:0] s, input logic a, input logic [7:0] exp);
        for (int i = 0; i < 8; i++) begin
            {ent3, ent2, ent1} = 3'(i);
            sel = s;
            act = a;
            #2;
            if (i > 0) chk({tag, "_hold"}, sal, exp[i-1]);
            @(posedge clk);
            #1;
            chk(tag, sal, exp[i]);
        end
    endtask
    task automatic step(input string tag, input logic [2:0] e, input logic a, input logic [2:0] s, input logic exp);
        {ent3, ent2, ent1} = e;
        act = a;
        sel = s;
        @(posedge clk);
        #1;
        chk(tag, sal, exp);
    endtask
    initial begin
        rst = 1'b0;
        act = 1'b1;
        sel = 3'b001;
        {ent3, ent2, ent1} = 3'b111;
        @(posedge clk);
        #1;
        chk("pre_rst", sal, 1'b1);
        #2 rst = 1'b1;
        #1 chk("rst_async", sal, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_hold", sal, 1'b0);
        rst = 1'b0;
        sweep("act0", 3'b001, 1'b0, 8'h00);
        sweep("off000", 3'b000, 1'b1, 8'h00);
        sweep("off111", 3'b111, 1'b1, 8'h00);
        sweep("and", 3'b001, 1'b1, 8'h80);
        sweep("or", 3'b010, 1'b1, 8'hFE);
        sweep("xor", 3'b011, 1'b1, 8'h96);
        sweep("xnor", 3'b110, 1'b1, 8'h69);
        sweep("nand", 3'b100, 1'b1, 8'h7F);
        sweep("nor", 3'b101, 1'b1, 8'h01);
        sweep("act0_or", 3'b010, 1'b0, 8'h00);
        step("mid_and", 3'b111, 1'b1, 3'b001, 1'b1);
        step("mid_nand", 3'b111, 1'b1, 3'b100, 1'b0);
        step("mid_newsel_newdata", 3'b011, 1'b1, 3'b011, 1'b0);
        step("mid_or", 3'b100, 1'b1, 3'b010, 1'b1);
        #2 rst = 1'b1;
        #1 chk("mid_rst", sal, 1'b0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        step("nand_pre", 3'b000, 1'b1, 3'b100, 1'b1);
        step("act_drop", 3'b000, 1'b0, 3'b100, 1'b0);
        step("act_resume", 3'b000, 1'b1, 3'b100, 1'b1);
        step("act_resume2", 3'b111, 1'b1, 3'b100, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/compuertas_logicas.md
Name: compuertas_logicas

Overview:
- Selectable 3-input logic gate with an enable and a registered output.
- Used as a small combinational-function unit whose gate type is chosen at run time by a 3-bit selector.
- Computes AND, OR, XOR, NAND, NOR or XNOR of three 1-bit inputs.
- Output is forced low when disabled or when the selector code is unused.

Parameters:
- None. The block is fixed at 3 data inputs and a 3-bit selector.

Ports:
- clk   input   1  rising-edge clock
- rst   input   1  asynchronous reset, active-high
- ent1  input   1  data input 1
- ent2  input   1  data input 2
- ent3  input   1  data input 3
- act   input   1  enable; 1 = gate active, 0 = output forced 0
- sel   input   3  gate select code (see Behaviour)
- sal   output  1  registered gate result

Interface rules:
- One clock; reset is asynchronous and active-high.
- All inputs are sampled on the rising edge of clk.
- sal is driven directly from a flip-flop, with no combinational path from input to output.

Behaviour:
- Reset: rst=1 immediately forces sal=0, independent of clk. It holds sal at 0 while asserted. The first update occurs on the first rising clk edge after rst deasserts.
- Latency: 1 cycle. sal after rising edge N equals f(ent1, ent2, ent3, act, sel) sampled at edge N.
- Selector decode (applies when act=1):
  - 3'b000: OFF, sal=0
  - 3'b001: AND, sal = ent1 & ent2 & ent3
  - 3'b010: OR, sal = ent1 | ent2 | ent3
  - 3'b011: XOR, sal = ent1 ^ ent2 ^ ent3 (odd parity; 1 when one or three inputs are high)
  - 3'b100: NAND, sal = ~(ent1 & ent2 & ent3)
  - 3'b101: NOR, sal = ~(ent1 | ent2 | ent3)
  - 3'b110: XNOR, sal = ~(ent1 ^ ent2 ^ ent3) (even parity)
  - 3'b111: OFF, sal=0
- Enable: act=0 gives sal=0 on the next edge for every sel and every input combination. act takes precedence over sel.
- Changing sel, act or the data inputs between edges has no effect until the next rising edge. There are no glitches on sal.
- Simultaneous changes of sel and data at the same edge: the new sel is applied to the new data, with no mixing of old and new values.
- Reset mid-operation: sal drops to 0 asynchronously. No state other than sal is retained.
- Unknown inputs: no X-propagation handling is required beyond standard RTL semantics. Benches drive known values after reset.

Test Plan:
- Reset and disable:
  - Assert rst with sel=3'b001, all ents=1: sal=0 immediately, without waiting for a clock edge.
  - Release rst with act=0: sal stays 0 for 8 cycles while all 8 input combinations are swept.
- Enable gating with an OFF code:
  - act=0→1 with sel=3'b000, sweep all 8 combinations: sal=0 throughout.
  - Repeat with sel=3'b111: sal=0 throughout.
- AND and OR exhaustive sweep (act=1, one combination per cycle, order 000..111 on {ent3, ent2, ent1}):
  - AND (sel=001): sal is 1 only for 111.
  - OR (sel=010): sal is 0 only for 000.
  - Each result appears one cycle after its inputs are applied.
- XOR and XNOR sweep (act=1):
  - XOR (sel=011): sal = 0,1,1,0,1,0,0,1 for combinations 000..111.
  - XNOR (sel=110): sal = 1,0,0,1,0,1,1,0.
- NAND and NOR sweep (act=1):
  - NAND (sel=100): sal is 0 only for 111.
  - NOR (sel=101): sal is 1 only for 000.
- Mid-stream events:
  - With ents=111, change sel from 001 to 100 at edge N: sal=1 after edge N-1, sal=0 after edge N.
  - Assert rst between edges: sal=0 at once.
  - Deassert act for one cycle: that cycle gives sal=0, then normal results resume.
